rr_stage: RTL and testbench
===========================

Name: rr_stage

Overview:
- Register-read stage of the Beta pipeline. It sits between decode and the ALU/execute stage, and drives both combinational read ports of the register file.
- It resolves operands using bypass from the EX, MEM and WB stages, and forces R31 reads to zero.
- It detects load-use interlocks and inserts bubbles.
- Its output is the RR/EX pipeline register: PC, opcode, destination, operands A/B and store data.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width; register 2**REG_AW-1 (R31) is the hardwired-zero register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode presents an instruction.
- id_instr  in  32  instruction: op[31:26], rc[25:21], ra[20:16], rb[15:11], lit[15:0].
- id_pc  in  32  PC+4 of the instruction.
- id_ready  out  1  stage accepts id_instr this cycle.
- rf_ra1  out  REG_AW  register-file read address 1 (= ra).
- rf_ra2  out  REG_AW  register-file read address 2 (rc for ST, otherwise rb).
- rf_rd1, rf_rd2  in  DATA_W  register-file read data, combinational.
- ex_fwd_valid, ex_fwd_wa[REG_AW], ex_fwd_data[DATA_W], ex_fwd_is_load  in  EX-stage writeback candidate.
- mem_fwd_valid, mem_fwd_wa[REG_AW], mem_fwd_data[DATA_W], mem_fwd_pending  in  MEM-stage candidate; pending = load data not yet returned.
- wb_fwd_valid, wb_fwd_wa[REG_AW], wb_fwd_data[DATA_W]  in  value being written to the register file this cycle.
- flush  in  1  squash from branch/JMP resolution.
- rr_ready  in  1  execute stage accepts.
- rr_valid  out  1; rr_pc  out  32; rr_op  out  6; rr_rc  out  REG_AW; rr_a, rr_b, rr_st_data  out  DATA_W.

Behaviour:
- Reset (async, immediate): rr_valid=0; rr_pc, rr_op, rr_rc, rr_a, rr_b and rr_st_data all 0. id_ready follows its combinational equation.
- Source usage by opcode:
  - OP (10xxxx): ra, rb.
  - OPC (11xxxx): ra.
  - LD (011000): ra.
  - ST (011001): ra, rc.
  - JMP (011011): ra.
  - BEQ/BNE (01110x): ra.
  - LDR (011111) and illegal opcodes: none.
- Operand resolution, per source register r, in priority order:
  1. r==R31 → 0.
  2. ex_fwd_valid && ex_fwd_wa==r → ex_fwd_data.
  3. mem match → mem_fwd_data.
  4. wb match → wb_fwd_data.
  5. Otherwise, register-file data.
  - A forward candidate whose wa==R31 never matches.
- Output operands:
  - rr_a = resolved ra.
  - rr_b = resolved rb for OP; sign-extended lit[15:0] for all other opcodes.
  - rr_st_data = resolved rc for ST, else 0.
  - rr_rc = rc.
- Hazard (combinational) is asserted when id_valid and a used source r≠R31 matches either:
  - a valid EX entry with ex_fwd_is_load, or
  - a valid MEM entry with mem_fwd_pending.
  - The highest-priority match decides: a younger non-load EX match masks an older pending MEM match.
- Handshakes:
  - hold = rr_valid && !rr_ready.
  - id_ready = !hazard && !hold.
- Register update, in priority order:
  1. flush → rr_valid=0 next cycle; flush wins over hold and load.
  2. hold → all rr_* keep their values.
  3. hazard or !id_valid → bubble (rr_valid=0, data don't-care/unchanged).
  4. Otherwise, load the resolved fields and set rr_valid=1.
- Latency: 1 cycle from acceptance to rr_valid. Throughput: 1 instruction/cycle with no hazard.
- Held operands are not re-resolved. Upstream guarantees that the producer does not retire past WB while the consumer is held; otherwise the held value stays captured.
- Reset asserted mid-stall clears rr_valid; the instruction is lost, and upstream is reset too.

Decomposition:
- beta_pkg holds:
  - opcode constants (OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR, OP class prefixes);
  - the R31 index constant;
  - instruction field bit positions;
  - a sign-extend function.
- Sub-module operand_bypass: one instance per source (ra, rb/rc). It takes a source address, the register-file data and the three forward candidates, and returns the resolved value plus a load_hazard flag.

Test Plan:
- Reset mid-run, rst=1 asynchronously → rr_valid=0 and rr_a=0 immediately, without a clock edge.
- ADD r3,r1,r2 with rf r1=5, r2=7, and ex_fwd r2=9 (non-load) → next cycle rr_a=5, rr_b=9, rr_valid=1.
- ex and wb both target r1 (ex=0x11, wb=0x22) → rr_a=0x11. Source r31 with ex_fwd_wa=31, data 0xFF → rr_a=0.
- LD into r4 in EX (is_load=1), then ADDC r5,r4,3 → id_ready=0 for 1 cycle with a bubble. Next cycle, mem_fwd r4=0x40, not pending → rr_a=0x40, rr_b=3.
- ST r6 → [r1+0xFFFC] with r6=0xAB → rr_b=0xFFFFFFFC, rr_st_data=0xAB. rr_ready=0 for 2 cycles → outputs stable and id_ready=0.
- flush asserted together with rr_ready=0 → rr_valid=0 next cycle. flush with hazard → rr_valid=0, no double issue.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared Beta ISA definitions: opcode encodings, instruction field
// positions, the hardwired-zero register index and immediate extension.
package beta_pkg;

    // Instruction field bit positions
    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 26;
    localparam int unsigned RC_HI  = 25;
    localparam int unsigned RC_LO  = 21;
    localparam int unsigned RA_HI  = 20;
    localparam int unsigned RA_LO  = 16;
    localparam int unsigned RB_HI  = 15;
    localparam int unsigned RB_LO  = 11;
    localparam int unsigned LIT_HI = 15;
    localparam int unsigned LIT_LO = 0;

    // Opcode class prefixes (op[5:4])
    localparam logic [1:0] OP_CLASS_OP  = 2'b10;
    localparam logic [1:0] OP_CLASS_OPC = 2'b11;

    // Individual memory / control-flow opcodes
    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_LDR = 6'b011111;

    // Hardwired-zero register for the default 5-bit register address
    localparam logic [4:0] R31 = 5'd31;

    // Sign-extend a 16-bit literal to 32 bits
    function automatic logic [31:0] sign_extend16(input logic [15:0] lit);
        return {{16{lit[15]}}, lit};
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand: R31 reads as zero, otherwise the youngest
// matching forward candidate (EX, MEM, WB) wins over register-file data.
// Also reports whether the deciding match is data that does not exist yet.
module operand_bypass
    import beta_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_wa_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              ex_is_load_i,
    input  logic              mem_valid_i,
    input  logic [REG_AW-1:0] mem_wa_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_pending_i,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_wa_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] value_o,
    output logic              load_hazard_o
);

    localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b1}};

    // Priority mux; a candidate writing R31 can never match because R31 is
    // filtered first, so later branches only see non-R31 sources.
    always_comb begin
        value_o       = rf_data_i;
        load_hazard_o = 1'b0;
        if (src_i == ZERO_REG) begin
            value_o       = {DATA_W{1'b0}};
            load_hazard_o = 1'b0;
        end else if (ex_valid_i && (ex_wa_i == src_i)) begin
            value_o       = ex_data_i;
            load_hazard_o = ex_is_load_i;
        end else if (mem_valid_i && (mem_wa_i == src_i)) begin
            value_o       = mem_data_i;
            load_hazard_o = mem_pending_i;
        end else if (wb_valid_i && (wb_wa_i == src_i)) begin
            value_o       = wb_data_i;
            load_hazard_o = 1'b0;
        end else begin
            value_o       = rf_data_i;
            load_hazard_o = 1'b0;
        end
    end

endmodule

// File: rtl/rr_stage.sv
// Beta register-read stage: drives register-file read ports, resolves
// operands with bypass, stalls on load-use, and holds the RR/EX register.
module rr_stage
    import beta_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc,
    output logic              id_ready,
    output logic [REG_AW-1:0] rf_ra1,
    output logic [REG_AW-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              ex_fwd_valid,
    input  logic [REG_AW-1:0] ex_fwd_wa,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              ex_fwd_is_load,
    input  logic              mem_fwd_valid,
    input  logic [REG_AW-1:0] mem_fwd_wa,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              mem_fwd_pending,
    input  logic              wb_fwd_valid,
    input  logic [REG_AW-1:0] wb_fwd_wa,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic              flush,
    input  logic              rr_ready,
    output logic              rr_valid,
    output logic [31:0]       rr_pc,
    output logic [5:0]        rr_op,
    output logic [REG_AW-1:0] rr_rc,
    output logic [DATA_W-1:0] rr_a,
    output logic [DATA_W-1:0] rr_b,
    output logic [DATA_W-1:0] rr_st_data
);

    logic [5:0]        op_s;
    logic [REG_AW-1:0] rc_s, ra_s, rb_s;
    logic [31:0]       sext_s;
    logic [DATA_W-1:0] imm_s;
    logic              is_st_s, is_op_s;
    logic              use_ra_s, use_r2_s;
    logic [DATA_W-1:0] res_a_s, res_2_s;
    logic              haz_a_s, haz_2_s;
    logic              hazard_s, hold_s;

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [5:0]        op_q, op_d;
    logic [REG_AW-1:0] rc_q, rc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, st_q, st_d;

    assign op_s    = id_instr[OP_HI:OP_LO];
    assign rc_s    = id_instr[RC_HI:RC_LO];
    assign ra_s    = id_instr[RA_HI:RA_LO];
    assign rb_s    = id_instr[RB_HI:RB_LO];
    assign sext_s  = sign_extend16(id_instr[LIT_HI:LIT_LO]);
    assign imm_s   = DATA_W'(signed'(sext_s));
    assign is_st_s = (op_s == OP_ST);
    assign is_op_s = (op_s[5:4] == OP_CLASS_OP);

    // Port 2 serves the store-data register for ST, otherwise rb.
    assign rf_ra1 = ra_s;
    assign rf_ra2 = is_st_s ? rc_s : rb_s;

    // Which source registers the opcode actually reads (ra on port 1, rb/rc on port 2)
    always_comb begin
        use_ra_s = 1'b0;
        use_r2_s = 1'b0;
        if (op_s[5:4] == OP_CLASS_OP) begin
            use_ra_s = 1'b1;
            use_r2_s = 1'b1;
        end else if (op_s[5:4] == OP_CLASS_OPC) begin
            use_ra_s = 1'b1;
            use_r2_s = 1'b0;
        end else begin
            case (op_s)
                OP_LD, OP_JMP, OP_BEQ, OP_BNE: begin
                    use_ra_s = 1'b1;
                    use_r2_s = 1'b0;
                end
                OP_ST: begin
                    use_ra_s = 1'b1;
                    use_r2_s = 1'b1;
                end
                OP_LDR: begin
                    use_ra_s = 1'b0;
                    use_r2_s = 1'b0;
                end
                default: begin
                    use_ra_s = 1'b0;
                    use_r2_s = 1'b0;
                end
            endcase
        end
    end

    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_a (
        .src_i(rf_ra1), .rf_data_i(rf_rd1),
        .ex_valid_i(ex_fwd_valid), .ex_wa_i(ex_fwd_wa), .ex_data_i(ex_fwd_data),
        .ex_is_load_i(ex_fwd_is_load),
        .mem_valid_i(mem_fwd_valid), .mem_wa_i(mem_fwd_wa), .mem_data_i(mem_fwd_data),
        .mem_pending_i(mem_fwd_pending),
        .wb_valid_i(wb_fwd_valid), .wb_wa_i(wb_fwd_wa), .wb_data_i(wb_fwd_data),
        .value_o(res_a_s), .load_hazard_o(haz_a_s)
    );

    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_2 (
        .src_i(rf_ra2), .rf_data_i(rf_rd2),
        .ex_valid_i(ex_fwd_valid), .ex_wa_i(ex_fwd_wa), .ex_data_i(ex_fwd_data),
        .ex_is_load_i(ex_fwd_is_load),
        .mem_valid_i(mem_fwd_valid), .mem_wa_i(mem_fwd_wa), .mem_data_i(mem_fwd_data),
        .mem_pending_i(mem_fwd_pending),
        .wb_valid_i(wb_fwd_valid), .wb_wa_i(wb_fwd_wa), .wb_data_i(wb_fwd_data),
        .value_o(res_2_s), .load_hazard_o(haz_2_s)
    );

    assign hazard_s = id_valid && ((use_ra_s && haz_a_s) || (use_r2_s && haz_2_s));
    assign hold_s   = valid_q && !rr_ready;
    assign id_ready = !hazard_s && !hold_s;

    // Next RR/EX contents: flush > hold > bubble > load
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        op_d    = op_q;
        rc_d    = rc_q;
        a_d     = a_q;
        b_d     = b_q;
        st_d    = st_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (hold_s) begin
            valid_d = valid_q;
        end else if (hazard_s || !id_valid) begin
            valid_d = 1'b0;
        end else begin
            valid_d = 1'b1;
            pc_d    = id_pc;
            op_d    = op_s;
            rc_d    = rc_s;
            a_d     = res_a_s;
            b_d     = is_op_s ? res_2_s : imm_s;
            st_d    = is_st_s ? res_2_s : {DATA_W{1'b0}};
        end
    end

    // RR/EX pipeline register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            op_q    <= 6'd0;
            rc_q    <= {REG_AW{1'b0}};
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            st_q    <= {DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            rc_q    <= rc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            st_q    <= st_d;
        end
    end

    assign rr_valid   = valid_q;
    assign rr_pc      = pc_q;
    assign rr_op      = op_q;
    assign rr_rc      = rc_q;
    assign rr_a       = a_q;
    assign rr_b       = b_q;
    assign rr_st_data = st_q;

endmodule

// File: tb/tb_rr_stage.sv
// Directed testbench for rr_stage: bypass priority, load-use stalls,
// store operands, back-pressure, flush and asynchronous reset.
module tb_rr_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    logic        id_ready;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_fwd_valid, ex_fwd_is_load;
    logic [4:0]  ex_fwd_wa;
    logic [31:0] ex_fwd_data;
    logic        mem_fwd_valid, mem_fwd_pending;
    logic [4:0]  mem_fwd_wa;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_wa;
    logic [31:0] wb_fwd_data;
    logic        flush, rr_ready;
    logic        rr_valid;
    logic [31:0] rr_pc;
    logic [5:0]  rr_op;
    logic [4:0]  rr_rc;
    logic [31:0] rr_a, rr_b, rr_st_data;

    logic [31:0] rf_mem [0:31];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Register-file model: combinational read
    assign rf_rd1 = rf_mem[rf_ra1];
    assign rf_rd2 = rf_mem[rf_ra2];

    rr_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(id_ready), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_wa(ex_fwd_wa), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_is_load(ex_fwd_is_load), .mem_fwd_valid(mem_fwd_valid), .mem_fwd_wa(mem_fwd_wa),
        .mem_fwd_data(mem_fwd_data), .mem_fwd_pending(mem_fwd_pending),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_wa(wb_fwd_wa), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .rr_ready(rr_ready), .rr_valid(rr_valid), .rr_pc(rr_pc), .rr_op(rr_op),
        .rr_rc(rr_rc), .rr_a(rr_a), .rr_b(rr_b), .rr_st_data(rr_st_data)
    );

    function automatic logic [31:0] enc_op(input logic [5:0] op, input logic [4:0] rc,
                                           input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] enc_lit(input logic [5:0] op, input logic [4:0] rc,
                                            input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_fwd_valid = 1'b0; ex_fwd_wa = 5'd0; ex_fwd_data = 32'd0; ex_fwd_is_load = 1'b0;
        mem_fwd_valid = 1'b0; mem_fwd_wa = 5'd0; mem_fwd_data = 32'd0; mem_fwd_pending = 1'b0;
        wb_fwd_valid = 1'b0; wb_fwd_wa = 5'd0; wb_fwd_data = 32'd0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rr_valid); end
        checks++; if (rr_a !== 32'd0) begin failures++; $display("FAIL reset_a got=%h exp=0", rr_a); end
        checks++; if (rr_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", rr_pc); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_id_ready got=%0b exp=1", id_ready); end
        #9;
        rst = 1'b0;
    endtask

    task automatic test_ex_bypass();
        clear_fwd();
        ex_fwd_valid = 1'b1; ex_fwd_wa = 5'd2; ex_fwd_data = 32'd9;
        id_valid = 1'b1; id_instr = enc_op(6'b100000, 5'd3, 5'd1, 5'd2); id_pc = 32'h104;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL exbyp_ready got=%0b exp=1", id_ready); end
        checks++; if (rf_ra1 !== 5'd1 || rf_ra2 !== 5'd2) begin failures++; $display("FAIL exbyp_addr got=%0d/%0d exp=1/2", rf_ra1, rf_ra2); end
        tick();
        checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL exbyp_valid got=%0b exp=1", rr_valid); end
        checks++; if (rr_a !== 32'd5) begin failures++; $display("FAIL exbyp_a got=%h exp=5", rr_a); end
        checks++; if (rr_b !== 32'd9) begin failures++; $display("FAIL exbyp_b got=%h exp=9", rr_b); end
        checks++; if (rr_rc !== 5'd3 || rr_op !== 6'b100000) begin failures++; $display("FAIL exbyp_rc_op got=%0d/%b exp=3/100000", rr_rc, rr_op); end
        checks++; if (rr_pc !== 32'h104 || rr_st_data !== 32'd0) begin failures++; $display("FAIL exbyp_pc_st got=%h/%h exp=104/0", rr_pc, rr_st_data); end
    endtask

    task automatic test_priority();
        clear_fwd();
        ex_fwd_valid = 1'b1; ex_fwd_wa = 5'd1; ex_fwd_data = 32'h11;
        wb_fwd_valid = 1'b1; wb_fwd_wa = 5'd1; wb_fwd_data = 32'h22;
        id_instr = enc_op(6'b100000, 5'd3, 5'd1, 5'd2);
        tick();
        checks++; if (rr_a !== 32'h11) begin failures++; $display("FAIL prio_ex_over_wb got=%h exp=11", rr_a); end
        checks++; if (rr_b !== 32'd7) begin failures++; $display("FAIL prio_rf_b got=%h exp=7", rr_b); end
        ex_fwd_valid = 1'b0;
        mem_fwd_valid = 1'b1; mem_fwd_wa = 5'd1; mem_fwd_data = 32'h33;
        tick();
        checks++; if (rr_a !== 32'h33) begin failures++; $display("FAIL prio_mem_over_wb got=%h exp=33", rr_a); end
        mem_fwd_valid = 1'b0;
        tick();
        checks++; if (rr_a !== 32'h22) begin failures++; $display("FAIL prio_wb got=%h exp=22", rr_a); end
        clear_fwd();
        ex_fwd_valid = 1'b1; ex_fwd_wa = 5'd31; ex_fwd_data = 32'hFF; ex_fwd_is_load = 1'b1;
        id_instr = enc_op(6'b100000, 5'd3, 5'd31, 5'd2);
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL r31_no_hazard got=%0b exp=1", id_ready); end
        tick();
        checks++; if (rr_a !== 32'd0 || rr_valid !== 1'b1) begin failures++; $display("FAIL r31_zero got=%h/%0b exp=0/1", rr_a, rr_valid); end
        checks++; if (rr_b !== 32'd7) begin failures++; $display("FAIL r31_b got=%h exp=7", rr_b); end
    endtask

    task automatic test_load_use();
        clear_fwd();
        ex_fwd_valid = 1'b1; ex_fwd_wa = 5'd4; ex_fwd_data = 32'hBAD; ex_fwd_is_load = 1'b1;
        id_instr = enc_lit(6'b110000, 5'd5, 5'd4, 16'd3); id_pc = 32'h120;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_ready got=%0b exp=0", id_ready); end
        tick();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0b exp=0", rr_valid); end
        clear_fwd();
        mem_fwd_valid = 1'b1; mem_fwd_wa = 5'd4; mem_fwd_data = 32'h40;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_release_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (rr_valid !== 1'b1 || rr_a !== 32'h40) begin failures++; $display("FAIL lu_mem_a got=%0b/%h exp=1/40", rr_valid, rr_a); end
        checks++; if (rr_b !== 32'd3 || rr_rc !== 5'd5) begin failures++; $display("FAIL lu_imm got=%h/%0d exp=3/5", rr_b, rr_rc); end
        mem_fwd_pending = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_mem_pending got=%0b exp=0", id_ready); end
        tick();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL lu_mem_bubble got=%0b exp=0", rr_valid); end
        ex_fwd_valid = 1'b1; ex_fwd_wa = 5'd4; ex_fwd_data = 32'h77; ex_fwd_is_load = 1'b0;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_ex_masks_mem got=%0b exp=1", id_ready); end
        tick();
        checks++; if (rr_a !== 32'h77 || rr_valid !== 1'b1) begin failures++; $display("FAIL lu_ex_masks_a got=%h/%0b exp=77/1", rr_a, rr_valid); end
        ex_fwd_is_load = 1'b1;
        id_instr = enc_lit(6'b011111, 5'd5, 5'd4, 16'h0000);
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL ldr_no_sources got=%0b exp=1", id_ready); end
        clear_fwd();
        mem_fwd_valid = 1'b1; mem_fwd_wa = 5'd2; mem_fwd_pending = 1'b1;
        id_instr = enc_lit(6'b011100, 5'd31, 5'd2, 16'h0010);
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL beq_pending got=%0b exp=0", id_ready); end
        clear_fwd();
    endtask

    task automatic test_store_hold();
        clear_fwd();
        id_valid = 1'b1; id_instr = enc_lit(6'b011001, 5'd6, 5'd1, 16'hFFFC); id_pc = 32'h200;
        #1;
        checks++; if (rf_ra2 !== 5'd6) begin failures++; $display("FAIL st_port2 got=%0d exp=6", rf_ra2); end
        tick();
        checks++; if (rr_b !== 32'hFFFFFFFC) begin failures++; $display("FAIL st_sext got=%h exp=fffffffc", rr_b); end
        checks++; if (rr_st_data !== 32'hAB || rr_a !== 32'd5) begin failures++; $display("FAIL st_data got=%h/%h exp=ab/5", rr_st_data, rr_a); end
        rr_ready = 1'b0;
        id_instr = enc_op(6'b100000, 5'd7, 5'd1, 5'd2); id_pc = 32'h204;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%0b exp=0", id_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rr_valid !== 1'b1 || rr_pc !== 32'h200 || rr_b !== 32'hFFFFFFFC || rr_st_data !== 32'hAB) begin
                failures++; $display("FAIL hold_stable cyc=%0d got=%0b/%h/%h/%h exp=1/200/fffffffc/ab", i, rr_valid, rr_pc, rr_b, rr_st_data);
            end
        end
        rr_ready = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%0b exp=1", id_ready); end
        tick();
        checks++; if (rr_pc !== 32'h204 || rr_st_data !== 32'd0 || rr_b !== 32'd7) begin failures++; $display("FAIL after_hold got=%h/%h/%h exp=204/0/7", rr_pc, rr_st_data, rr_b); end
    endtask

    task automatic test_flush();
        rr_ready = 1'b0; flush = 1'b1;
        tick();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL flush_over_hold got=%0b exp=0", rr_valid); end
        rr_ready = 1'b1;
        ex_fwd_valid = 1'b1; ex_fwd_wa = 5'd1; ex_fwd_is_load = 1'b1;
        id_instr = enc_op(6'b100000, 5'd3, 5'd1, 5'd2);
        tick();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL flush_hazard got=%0b exp=0", rr_valid); end
        clear_fwd();
        tick();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL flush_load got=%0b exp=0", rr_valid); end
        flush = 1'b0; id_valid = 1'b0;
        tick();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL flush_no_reissue got=%0b exp=0", rr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        id_valid = 1'b1; rr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h300 + 32'(i * 4);
            id_pc = exp_pc;
            id_instr = enc_op(6'b100000, 5'(10 + i), 5'd1, 5'd2);
            tick();
            checks++;
            if (rr_valid !== 1'b1 || rr_pc !== exp_pc || rr_rc !== 5'(10 + i)) begin
                failures++; $display("FAIL b2b_%0d got=%0b/%h/%0d exp=1/%h/%0d", i, rr_valid, rr_pc, rr_rc, exp_pc, 10 + i);
            end
        end
        id_valid = 1'b0;
        tick();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b exp=0", rr_valid); end
    endtask

    task automatic test_async_reset();
        id_valid = 1'b1; id_instr = enc_op(6'b100000, 5'd3, 5'd1, 5'd2); id_pc = 32'h400;
        rr_ready = 1'b0;
        tick();
        checks++; if (rr_valid !== 1'b1 || rr_a !== 32'd5) begin failures++; $display("FAIL arst_pre got=%0b/%h exp=1/5", rr_valid, rr_a); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rr_valid !== 1'b0 || rr_a !== 32'd0 || rr_pc !== 32'd0) begin failures++; $display("FAIL arst_immediate got=%0b/%h/%h exp=0/0/0", rr_valid, rr_a, rr_pc); end
        #1;
        rst = 1'b0;
        id_valid = 1'b0; rr_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + 32'(i);
        rf_mem[1] = 32'd5; rf_mem[2] = 32'd7; rf_mem[6] = 32'hAB; rf_mem[31] = 32'hDEAD;
        rst = 1'b1; id_valid = 1'b0; id_instr = 32'd0; id_pc = 32'd0;
        flush = 1'b0; rr_ready = 1'b1;
        clear_fwd();
        test_reset();
        tick();
        test_ex_bypass();
        test_priority();
        test_load_use();
        test_store_hold();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
